enemy_hit_dispatcher: RTL

Drives the enemy-column side of the hit/pointer interface. Once per frame, it scans the player bullet position against every live enemy column. On a match it issues a one-cycle hit pulse to exactly one column and reports the bullet as consumed. It also rotates a one-hot "pointed-to" selector across live columns to choose which column fires next. It sits between the player-bullet logic and the array of enemy columns in the top-level game datapath.

---
 rtl/enemy_hit_dispatcher_pkg.sv | 17 +
 rtl/enemy_hit_dispatcher_if.sv | 43 ++++
 rtl/enemy_hit_dispatcher_column_pointer.sv | 78 +++++++
 rtl/enemy_hit_dispatcher.sv | 116 +++++++++++
 4 files changed

// File: rtl/enemy_hit_dispatcher_pkg.sv
// enemy_pkg: shared constants and types for the enemy hit dispatcher.
// Contents:
//   COORD_W          width of every pixel coordinate on the hit interface
//   DEFAULT_COLUMNS  column count used when a parameter is left at its default
//   hit_state_t      hit FSM state, one-hot encoded
package enemy_pkg;

    localparam int COORD_W         = 10;
    localparam int DEFAULT_COLUMNS = 8;

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        SCAN = 3'b010,
        HIT  = 3'b100
    } hit_state_t;

endpackage

// File: rtl/enemy_hit_dispatcher_if.sv
// enemy_hit_dispatcher_if: bundle between the game datapath and the enemy
// hit dispatcher.
// Signals:
//   frame_i, bullet_valid_i, bullet_x_i, bullet_y_i  player bullet / frame timing
//   column_left_i, column_right_i, column_bot_i      packed per-column geometry,
//                                                    column k in bits [10k+9:10k]
//   column_dead_i                                    per-column all-dead flags
//   hit_o, bullet_consumed_o                         hit pulse back to the columns
//   pointed_to_o, fire_o                             firing column selector
//   all_cleared_o                                    every column is dead
// Modports: master = game datapath side, slave = dispatcher side.
interface enemy_hit_dispatcher_if #(
    parameter int num_columns_p = enemy_pkg::DEFAULT_COLUMNS
);
    import enemy_pkg::*;

    logic                               frame_i;
    logic                               bullet_valid_i;
    logic [COORD_W-1:0]                 bullet_x_i;
    logic [COORD_W-1:0]                 bullet_y_i;
    logic [COORD_W*num_columns_p-1:0]   column_left_i;
    logic [COORD_W*num_columns_p-1:0]   column_right_i;
    logic [COORD_W*num_columns_p-1:0]   column_bot_i;
    logic [num_columns_p-1:0]           column_dead_i;
    logic [num_columns_p-1:0]           hit_o;
    logic                               bullet_consumed_o;
    logic [num_columns_p-1:0]           pointed_to_o;
    logic                               fire_o;
    logic                               all_cleared_o;

    modport master (
        output frame_i, bullet_valid_i, bullet_x_i, bullet_y_i,
               column_left_i, column_right_i, column_bot_i, column_dead_i,
        input  hit_o, bullet_consumed_o, pointed_to_o, fire_o, all_cleared_o
    );

    modport slave (
        input  frame_i, bullet_valid_i, bullet_x_i, bullet_y_i,
               column_left_i, column_right_i, column_bot_i, column_dead_i,
        output hit_o, bullet_consumed_o, pointed_to_o, fire_o, all_cleared_o
    );

endinterface

// File: rtl/enemy_hit_dispatcher_column_pointer.sv
// column_pointer: chooses which enemy column fires next.
// Counts frame pulses; every fire_interval_p frames the pointer moves to the
// next column and keeps stepping past dead columns, one per cycle, until it
// lands on a live one (fire pulses) or has gone all the way round (no fire).
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   frame        one-cycle pulse per video frame
//   column_dead  per-column all-dead flags
//   pointed_to   registered one-hot copy of the pointer
//   fire         one-cycle pulse when the pointed-to column should fire
module column_pointer
    import enemy_pkg::*;
#(
    parameter int num_columns_p   = DEFAULT_COLUMNS,
    parameter int fire_interval_p = 60
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame,
    input  logic [num_columns_p-1:0] column_dead,
    output logic [num_columns_p-1:0] pointed_to,
    output logic                     fire
);

    localparam int PTR_W = $clog2(num_columns_p);
    localparam int CNT_W = (fire_interval_p > 1) ? $clog2(fire_interval_p) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(num_columns_p - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(fire_interval_p - 1);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] next_ptr;
    logic [PTR_W-1:0] steps;
    logic [CNT_W-1:0] frame_cnt;
    logic             searching;
    logic             expire;

    // The step decision looks one column ahead: the column the pointer is
    // about to land on is tested in the same cycle it moves, which makes
    // fire_o appear d cycles after the expiring frame for a column d away.
    always_comb begin
        expire   = frame && (frame_cnt == LAST_CNT);
        next_ptr = (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
    end

    // steps counts pointer moves in this search (the expiry move is the
    // first); after num_columns_p moves the pointer is back where it started.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt  <= '0;
            ptr        <= '0;
            pointed_to <= num_columns_p'(1);
            steps      <= '0;
            searching  <= 1'b0;
            fire       <= 1'b0;
        end else begin
            fire <= 1'b0;
            if (frame) begin
                frame_cnt <= expire ? '0 : frame_cnt + CNT_W'(1);
            end
            if (expire || searching) begin
                ptr        <= next_ptr;
                pointed_to <= num_columns_p'(1) << next_ptr;
                if (!column_dead[next_ptr]) begin
                    fire      <= 1'b1;
                    searching <= 1'b0;
                end else if (expire) begin
                    searching <= 1'b1;
                    steps     <= PTR_W'(1);
                end else if (steps == LAST_PTR) begin
                    searching <= 1'b0;
                end else begin
                    steps <= steps + PTR_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/enemy_hit_dispatcher.sv
// enemy_hit_dispatcher: once per frame, scans the player bullet against the
// enemy columns one column per cycle and pulses hit_o on the lowest-index
// column it overlaps; also hosts the column_pointer that picks the firing
// column.
// Ports:
//   clk_i, reset_i  clock, asynchronous active-high reset
//   bus             enemy_hit_dispatcher_if slave side (see interface header)
module enemy_hit_dispatcher
    import enemy_pkg::*;
#(
    parameter int num_columns_p   = DEFAULT_COLUMNS,
    parameter int fire_interval_p = 60
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    enemy_hit_dispatcher_if.slave bus
);

    localparam int IDX_W = $clog2(num_columns_p);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(num_columns_p - 1);

    logic [COORD_W-1:0]       left_edge  [num_columns_p];
    logic [COORD_W-1:0]       right_edge [num_columns_p];
    logic [COORD_W-1:0]       bot_edge   [num_columns_p];

    hit_state_t               state;
    hit_state_t               state_next;
    logic [IDX_W-1:0]         idx;
    logic [IDX_W-1:0]         idx_next;
    logic [num_columns_p-1:0] hit_next;
    logic                     consumed_next;
    logic                     match;

    // Unpack the column geometry buses into per-column arrays.
    always_comb begin
        for (int k = 0; k < num_columns_p; k++) begin
            left_edge[k]  = bus.column_left_i[k*COORD_W +: COORD_W];
            right_edge[k] = bus.column_right_i[k*COORD_W +: COORD_W];
            bot_edge[k]   = bus.column_bot_i[k*COORD_W +: COORD_W];
        end
    end

    // A column is hit when it still has enemies, the bullet x lies inside
    // its edges and the bullet top is at or above its lowest enemy.
    always_comb begin
        match = !bus.column_dead_i[idx]
             && (left_edge[idx] <= bus.bullet_x_i)
             && (bus.bullet_x_i <= right_edge[idx])
             && (bus.bullet_y_i <= bot_edge[idx]);
    end

    // Next-state logic. The hit pulse is computed on the way into HIT and
    // registered, so it is high for exactly the cycle spent in HIT.
    always_comb begin
        state_next    = state;
        idx_next      = idx;
        hit_next      = '0;
        consumed_next = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.frame_i && bus.bullet_valid_i) begin
                    state_next = SCAN;
                    idx_next   = '0;
                end
            end
            SCAN: begin
                if (!bus.bullet_valid_i) begin
                    state_next = IDLE;
                end else if (match) begin
                    state_next    = HIT;
                    hit_next[idx] = 1'b1;
                    consumed_next = 1'b1;
                end else if (idx == LAST_IDX) begin
                    state_next = IDLE;
                end else begin
                    idx_next = idx + IDX_W'(1);
                end
            end
            HIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state                 <= IDLE;
            idx                   <= '0;
            bus.hit_o             <= '0;
            bus.bullet_consumed_o <= 1'b0;
            bus.all_cleared_o     <= 1'b0;
        end else begin
            state                 <= state_next;
            idx                   <= idx_next;
            bus.hit_o             <= hit_next;
            bus.bullet_consumed_o <= consumed_next;
            bus.all_cleared_o     <= &bus.column_dead_i;
        end
    end

    column_pointer #(
        .num_columns_p   (num_columns_p),
        .fire_interval_p (fire_interval_p)
    ) u_column_pointer (
        .clk         (clk_i),
        .rst         (reset_i),
        .frame       (bus.frame_i),
        .column_dead (bus.column_dead_i),
        .pointed_to  (bus.pointed_to_o),
        .fire        (bus.fire_o)
    );

endmodule
